// File: rtl/dla_pkg.sv
// Shared constants and types for the DLA particle walker: display geometry, FSM state
// encoding, walk direction table and LFSR taps.
package dla_pkg;

  localparam int unsigned H_SIZE    = 10;
  localparam int unsigned V_SIZE    = 9;
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;

  localparam logic [H_SIZE-1:0] SEED_X    = H_SIZE'(H_DISPLAY / 2);
  localparam logic [V_SIZE-1:0] SEED_Y    = V_SIZE'(V_DISPLAY / 2);
  localparam logic [15:0]       LFSR_TAPS = 16'hB400;

  typedef enum logic [7:0] {
    StIdle  = 8'h01,
    StSeed  = 8'h02,
    StSpawn = 8'h04,
    StCheck = 8'h08,
    StWait  = 8'h10,
    StMove  = 8'h20,
    StStick = 8'h40,
    StFin   = 8'h80
  } state_e;

  // Two-bit two's-complement step per direction code: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
  localparam logic [1:0] DIR_DX [8] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};
  localparam logic [1:0] DIR_DY [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

  function automatic logic [31:0] pix_addr(input logic [H_SIZE-1:0] x,
                                           input logic [V_SIZE-1:0] y);
    return 32'(x) + 32'(y) * 32'(H_DISPLAY);
  endfunction

endpackage

// File: rtl/dla_lfsr.sv
// 16-bit Galois LFSR, right-shifting, free-running from reset.
module dla_lfsr
  import dla_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/dla_particle_walk.sv
// Diffusion-limited aggregation walker: seeds the centre pixel, then spawns random walkers
// that move until an external checker reports a neighbour (stick) or the boundary (respawn).
// Optional DLA_WALK_STEP_LIMIT_EN abandons a walker after MAX_STEPS moves without a hit.
module dla_particle_walk
  import dla_pkg::*;
#(
  parameter int unsigned AVN_AW    = 19,
  parameter int unsigned AVN_DW    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_STEPS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_particles,
  output logic              busy,
  output logic              done,
  output logic [15:0]       particle_count,
  output logic [H_SIZE-1:0] check_x,
  output logic [V_SIZE-1:0] check_y,
  output logic              check_start,
  input  logic              check_done,
  input  logic              hit_boundary,
  input  logic              hit_neighbor,
  output logic [AVN_AW-1:0] vram_avn_address,
  output logic              vram_avn_write,
  output logic [AVN_DW-1:0] vram_avn_writedata,
  input  logic              vram_avn_waitrequest
);

  state_e              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_check_start;
  logic                r_write;
  logic [AVN_AW-1:0]   r_addr;
  logic [15:0]         r_count;
  logic [15:0]         r_num;
  logic [H_SIZE-1:0]   r_check_x;
  logic [V_SIZE-1:0]   r_check_y;

  logic [15:0]         w_lfsr;
  logic [H_SIZE-1:0]   w_cand_x;
  logic [V_SIZE-1:0]   w_cand_y;
  logic                w_cand_ok;
  logic [1:0]          w_dx;
  logic [1:0]          w_dy;
  logic [15:0]         w_count_inc;
  logic                w_unused;

`ifdef DLA_WALK_STEP_LIMIT_EN
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0]   r_steps;
`endif

  dla_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_lfsr (w_lfsr)
  );

  assign w_cand_x    = w_lfsr[H_SIZE-1:0];
  assign w_cand_y    = w_lfsr[V_SIZE-1:0];
  assign w_cand_ok   = (w_cand_x >= H_SIZE'(1)) && (w_cand_x <= H_SIZE'(H_DISPLAY - 2)) &&
                       (w_cand_y >= V_SIZE'(1)) && (w_cand_y <= V_SIZE'(V_DISPLAY - 2));
  assign w_dx        = DIR_DX[w_lfsr[2:0]];
  assign w_dy        = DIR_DY[w_lfsr[2:0]];
  assign w_count_inc = r_count + 16'd1;
  // Upper LFSR bits are not consumed; MAX_STEPS is referenced even when the limit is compiled out.
  assign w_unused    = ^{w_lfsr[15:H_SIZE], (MAX_STEPS == 32'd0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_check_start <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_count       <= '0;
      r_num         <= '0;
      r_check_x     <= '0;
      r_check_y     <= '0;
`ifdef DLA_WALK_STEP_LIMIT_EN
      r_steps       <= '0;
`endif
    end else begin
      r_done        <= 1'b0;
      r_check_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
            r_num   <= num_particles;
            r_write <= 1'b1;
            r_addr  <= AVN_AW'(pix_addr(SEED_X, SEED_Y));
            r_state <= StSeed;
          end
        end
        StSeed: begin
          if (!vram_avn_waitrequest) begin
            r_write <= 1'b0;
            if (r_num == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_state <= StSpawn;
            end
          end
        end
        StSpawn: begin
`ifdef DLA_WALK_STEP_LIMIT_EN
          r_steps <= '0;
`endif
          if (w_cand_ok) begin
            r_check_x     <= w_cand_x;
            r_check_y     <= w_cand_y;
            r_check_start <= 1'b1;
            r_state       <= StCheck;
          end
        end
        StCheck: r_state <= StWait;
        StWait: begin
          if (check_done) begin
            if (hit_boundary) begin
              r_state <= StSpawn;
            end else if (hit_neighbor) begin
              r_write <= 1'b1;
              r_addr  <= AVN_AW'(pix_addr(r_check_x, r_check_y));
              r_state <= StStick;
            end else begin
`ifdef DLA_WALK_STEP_LIMIT_EN
              r_state <= (r_steps == STEP_W'(MAX_STEPS)) ? StSpawn : StMove;
`else
              r_state <= StMove;
`endif
            end
          end
        end
        StMove: begin
          // Wraps modulo the coordinate width; the checker flags edge positions as boundary.
          r_check_x     <= r_check_x + {{(H_SIZE - 2){w_dx[1]}}, w_dx};
          r_check_y     <= r_check_y + {{(V_SIZE - 2){w_dy[1]}}, w_dy};
          r_check_start <= 1'b1;
          r_state       <= StCheck;
`ifdef DLA_WALK_STEP_LIMIT_EN
          r_steps       <= r_steps + STEP_W'(1);
`endif
        end
        StStick: begin
          if (!vram_avn_waitrequest) begin
            r_write <= 1'b0;
            r_count <= w_count_inc;
            if (w_count_inc == r_num) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_state <= StSpawn;
            end
          end
        end
        StFin: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign particle_count     = r_count;
  assign check_x            = r_check_x;
  assign check_y            = r_check_y;
  assign check_start        = r_check_start;
  assign vram_avn_address   = r_addr;
  assign vram_avn_write     = r_write;
  assign vram_avn_writedata = {AVN_DW{1'b1}};

endmodule

// File: tb/tb_dla_particle_walk.sv
// Self-checking bench for dla_particle_walk: checker/VRAM responder plus a cycle-level
// reference of spawn, move and write behaviour driven from the Galois LFSR rule.
module tb_dla_particle_walk;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   num_particles;
  logic          busy;
  logic          done;
  logic [15:0]   particle_count;
  logic [9:0]    check_x;
  logic [8:0]    check_y;
  logic          check_start;
  logic          check_done;
  logic          hit_boundary;
  logic          hit_neighbor;
  logic [AW-1:0] vram_avn_address;
  logic          vram_avn_write;
  logic [DW-1:0] vram_avn_writedata;
  logic          vram_avn_waitrequest;

  dla_particle_walk #(
    .AVN_AW    (AW),
    .AVN_DW    (DW),
    .LFSR_SEED (16'hACE1),
    .MAX_STEPS (4096)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .num_particles        (num_particles),
    .busy                 (busy),
    .done                 (done),
    .particle_count       (particle_count),
    .check_x              (check_x),
    .check_y              (check_y),
    .check_start          (check_start),
    .check_done           (check_done),
    .hit_boundary         (hit_boundary),
    .hit_neighbor         (hit_neighbor),
    .vram_avn_address     (vram_avn_address),
    .vram_avn_write       (vram_avn_write),
    .vram_avn_writedata   (vram_avn_writedata),
    .vram_avn_waitrequest (vram_avn_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] galois_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR value for the current cycle (valid when sampled at negedge).
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= galois_next(m_lfsr);
  end

  // Run configuration (written by the main sequence) and model state.
  int          num_cfg = 0;
  int          resp_mode = 0;   // 0: always neighbour, 1: scripted, 2: random
  int          stall_cfg = 0;   // <0: random 0..2 wait cycles per write
  bit          hold_resp = 0;
  int          script_q[$];
  logic [31:0] exp_addr_q[$];
  int          writes_run = 0;
  int          m_count = 0;
  int          done_cnt = 0;
  int          spawn_cnt = 0;

  bit          waiting, expect_now, expect_next, spawn_active, spawn_arm, move_pend, move_arm;
  bit          in_write;
  int          resp_wait, stall_left, r, d, dx, dy;
  logic [9:0]  cur_x, exp_x;
  logic [8:0]  cur_y, exp_y;
  logic [31:0] held_addr;

  initial begin
    check_done = 0; hit_boundary = 0; hit_neighbor = 0; vram_avn_waitrequest = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        waiting = 0; expect_now = 0; expect_next = 0; spawn_active = 0; spawn_arm = 0;
        move_pend = 0; move_arm = 0; in_write = 0;
        check_done = 0; hit_boundary = 0; hit_neighbor = 0; vram_avn_waitrequest = 0;
        continue;
      end
      // Checker responder: result lands in a WAIT cycle 1..3 cycles after the request.
      if (check_done) begin
        check_done = 0; hit_boundary = 0; hit_neighbor = 0;
      end else if (waiting) begin
        chk("check_pos_stable", {13'd0, check_y, check_x}, {13'd0, cur_y, cur_x});
        if (!hold_resp) begin
          resp_wait--;
          if (resp_wait == 0) begin
            if (resp_mode == 0) r = 1;
            else if (resp_mode == 1) r = (script_q.size() != 0) ? script_q.pop_front() : 1;
            else if (cur_x == 0 || cur_x >= 639 || cur_y == 0 || cur_y >= 479 ||
                     $urandom_range(0, 15) == 0) r = 2;
            else r = ($urandom_range(0, 3) == 0) ? 1 : 0;
            check_done   = 1;
            hit_boundary = (r == 2);
            hit_neighbor = (r == 1) || (r == 2 && $urandom_range(0, 1) == 1);
            waiting = 0;
            if (r == 2) spawn_arm = 1;
            else if (r == 1) exp_addr_q.push_back(32'(cur_x) + 32'(cur_y) * 32'd640);
            else move_arm = 1;
          end
        end
      end
      // check_start must pulse exactly when a spawn or move was predicted.
      chk("check_start", {31'd0, check_start}, {31'd0, expect_now});
      if (check_start && expect_now) begin
        chk("check_pos", {13'd0, check_y, check_x}, {13'd0, exp_y, exp_x});
        cur_x = exp_x; cur_y = exp_y;
        waiting = 1;
        resp_wait = $urandom_range(1, 3);
      end
      // Spawn: first cycle whose low LFSR bits land strictly inside the display.
      if (spawn_active) begin
        if (m_lfsr[9:0] >= 10'd1 && m_lfsr[9:0] <= 10'd638 &&
            m_lfsr[8:0] >= 9'd1 && m_lfsr[8:0] <= 9'd478) begin
          exp_x = m_lfsr[9:0]; exp_y = m_lfsr[8:0];
          expect_next = 1; spawn_active = 0; spawn_cnt++;
        end
      end
      if (move_pend) begin
        d  = int'(m_lfsr[2:0]);
        dx = (d == 0 || d == 3 || d == 5) ? -1 : ((d == 1 || d == 6) ? 0 : 1);
        dy = (d < 3) ? -1 : ((d < 5) ? 0 : 1);
        exp_x = cur_x + 10'(dx);
        exp_y = cur_y + 9'(dy);
        expect_next = 1; move_pend = 0;
      end
      // VRAM slave with optional wait states.
      if (vram_avn_write) begin
        if (!in_write) begin
          in_write   = 1;
          stall_left = (stall_cfg < 0) ? $urandom_range(0, 2) : stall_cfg;
          held_addr  = 32'(vram_avn_address);
        end else begin
          chk("write_addr_stable", 32'(vram_avn_address), held_addr);
        end
        chk("write_data", 32'(vram_avn_writedata), 32'h0000FFFF);
        if (stall_left > 0) begin
          vram_avn_waitrequest = 1; stall_left--;
        end else begin
          vram_avn_waitrequest = 0; in_write = 0;
          if (exp_addr_q.size() == 0) chk("write_unexpected", 32'(vram_avn_address), 32'hFFFFFFFF);
          else chk("write_addr", 32'(vram_avn_address), exp_addr_q.pop_front());
          if (writes_run == 0) begin
            if (num_cfg != 0) spawn_arm = 1;
          end else begin
            m_count++;
            if (m_count != num_cfg) spawn_arm = 1;
          end
          writes_run++;
        end
      end else begin
        if (in_write) chk("write_held", {31'd0, vram_avn_write}, 32'd1);
        in_write = 0;
        vram_avn_waitrequest = 0;
      end
      if (done) done_cnt++;
      expect_now = expect_next; expect_next = 0;
      if (spawn_arm) spawn_active = 1;
      spawn_arm = 0;
      move_pend = move_arm; move_arm = 0;
    end
  end

  task automatic setup_run(input int n, input int mode, input int stall);
    exp_addr_q.delete();
    exp_addr_q.push_back(32'd153920);
    num_cfg = n; resp_mode = mode; stall_cfg = stall;
    writes_run = 0; m_count = 0; done_cnt = 0; spawn_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_check_start"}, {31'd0, check_start}, 32'd0);
    chk({tag, "_write"}, {31'd0, vram_avn_write}, 32'd0);
    chk({tag, "_count"}, 32'(particle_count), 32'd0);
    chk({tag, "_check_x"}, 32'(check_x), 32'd0);
    chk({tag, "_check_y"}, 32'(check_y), 32'd0);
  endtask

  task automatic run(input int n, input int mode, input int stall);
    int cyc;
    setup_run(n, mode, stall);
    start = 1; num_particles = 16'(n);
    @(negedge clk);
    start = 0; num_particles = 16'($urandom);
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      start = (cyc == 3);   // ignored while busy
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("count_at_done", 32'(particle_count), 32'(n));
    @(negedge clk);
    chk("busy_after_fin", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("writes_total", 32'(writes_run), 32'(n + 1));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("count_hold", 32'(particle_count), 32'(n));
    if (cyc >= 20000) begin
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 0; start = 0; num_particles = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    run(0, 0, 0);                        // seed only
    run(3, 0, -1);                       // immediate neighbour on every walker
    script_q = '{2, 2, 1};
    run(1, 1, 0);                        // two boundary respawns, then stick
    chk("respawns", 32'(spawn_cnt), 32'd3);
    run(2, 0, 5);                        // five wait states on every write
    for (int i = 0; i < 4; i++) run($urandom_range(4, 8), 2, -1);

    // Abort mid-WAIT with the checker withholding its answer.
    setup_run(5, 2, 0);
    hold_resp = 1;
    start = 1; num_particles = 16'd5;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (check_start !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_check_seen", {31'd0, check_start}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs("abort");
    hold_resp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(3, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
